arbitro_memoria: RTL and testbench

Two-port arbiter and access sequencer for the single-port 64 x 16 main memory (`memoram`). It shares the memory between two requesters: port 0, the L1/L2 miss-refill path, and port 1, the dirty-line write-back path. It drives the RAM's address, data and write-enable from registers, absorbs the RAM's two-cycle registered read latency, and returns one-cycle acknowledges, so no cache logic needs delay statements.

---
 rtl/arbitro_memoria.sv | 116 +++++++++++
 tb/tb_arbitro_memoria.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria.sv
// Two-port arbiter/sequencer for the single-port 64x16 memoram with 2-cycle registered read latency.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break; undefined = port 0 fixed priority.
module arbitro_memoria #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, LATCH, DONE} state_t;

  state_t          state, state_nxt;
  logic            id, we_r, last_grant;
  logic            win, any_req, we_sel;
  logic [AW-1:0]   addr_sel;
  logic [DW-1:0]   wdata_sel;
  logic            do_grant, do_latch, wren_nxt, ack0_nxt, ack1_nxt, busy_nxt;

  assign any_req = req0 | req1;

  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~last_grant;
`else
      win = 1'b0;
`endif
    end else begin
      win = req1;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority never consults the grant history, but it is still tracked.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  assign we_sel    = win ? we1    : we0;
  assign addr_sel  = win ? addr1  : addr0;
  assign wdata_sel = win ? wdata1 : wdata0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_r ? DONE : WAIT;
      WAIT:    state_nxt = LATCH;
      LATCH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_grant = (state == IDLE) && any_req;
    do_latch = (state == LATCH);
    wren_nxt = do_grant && we_sel;
    ack0_nxt = (state == DONE) && !id;
    ack1_nxt = (state == DONE) && id;
    busy_nxt = (state_nxt != IDLE);
  end

  // Output/datapath registers; the ack lands in the cycle after DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      rdata       <= '0;
      id          <= 1'b0;
      we_r        <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      ack0     <= ack0_nxt;
      ack1     <= ack1_nxt;
      busy     <= busy_nxt;
      mem_wren <= wren_nxt;
      if (do_grant) begin
        id          <= win;
        last_grant  <= win;
        we_r        <= we_sel;
        mem_address <= addr_sel;
        mem_data    <= wdata_sel;
      end
      if (do_latch) rdata <= mem_q;
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: vector table plus hand sequences, scoreboard checked on ack.
module tb_arbitro_memoria;
  localparam int AW = 6;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, mem_wren;
  logic [DW-1:0] rdata, mem_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_q = '0;

  arbitro_memoria #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // memoram model: registered address/data in, registered q out
  logic [DW-1:0] ram [0:63];
  logic [AW-1:0] ram_addr_r = '0;
  logic          ram_init = 1'b1;
  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
      ram[1] <= 16'h1111;
      ram[2] <= 16'h2222;
      ram[5] <= 16'hBEEF;
      ram_init <= 1'b0;
    end else begin
      if (mem_wren) ram[mem_address] <= mem_data;
      ram_addr_r <= mem_address;
      mem_q      <= ram[ram_addr_r];
    end
  end

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic          port;
    logic          rd;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0, cyc = 0, wren_cnt = 0;
  vec_t vecs[9];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every ack must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (mem_wren) wren_cnt++;
      if (ack0 || ack1) begin
        check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        if (sb.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("ack_port", 32'(ack1), 32'(e.port));
          check("ack_cycle", 32'(cyc), 32'(e.cyc));
          if (e.rd) check("rdata", 32'(rdata), 32'(e.rdata));
        end
      end
    end
  end

  task automatic push_exp(input logic port, input logic rd, input logic [DW-1:0] d, input int c);
    exp_t e;
    e.port = port; e.rd = rd; e.rdata = d; e.cyc = c;
    sb.push_back(e);
  endtask

  // Drive one request at a negedge; req drops one cycle after the grant edge.
  task automatic issue(input vec_t v);
    @(negedge clock);
    wren_cnt = 0;
    if (v.port) begin
      req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    push_exp(v.port, !v.we, v.exp, cyc + 1 + (v.we ? 2 : 4));
    @(negedge clock);
    req0 = 0; req1 = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clock);
    @(negedge clock);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack0"}, 32'(ack0), 32'd0);
    check({tag, "_ack1"}, 32'(ack1), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_addr"}, 32'(mem_address), 32'd0);
    check({tag, "_data"}, 32'(mem_data), 32'd0);
    check({tag, "_wren"}, 32'(mem_wren), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e0;
    bit  done;
    vecs[0] = '{port:0, we:0, addr:6'h05, wdata:16'h0000, exp:16'hBEEF};
    vecs[1] = '{port:1, we:1, addr:6'h3F, wdata:16'h1234, exp:16'h0000};
    vecs[2] = '{port:0, we:0, addr:6'h3F, wdata:16'h0000, exp:16'h1234};
    vecs[3] = '{port:1, we:0, addr:6'h05, wdata:16'h0000, exp:16'hBEEF};
    vecs[4] = '{port:0, we:1, addr:6'h00, wdata:16'hA5A5, exp:16'h0000};
    vecs[5] = '{port:1, we:0, addr:6'h00, wdata:16'h0000, exp:16'hA5A5};
    vecs[6] = '{port:1, we:1, addr:6'h3F, wdata:16'hFFFF, exp:16'h0000};
    vecs[7] = '{port:0, we:0, addr:6'h3F, wdata:16'h0000, exp:16'hFFFF};
    vecs[8] = '{port:0, we:0, addr:6'h01, wdata:16'h0000, exp:16'h1111};

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 0;

    foreach (vecs[i]) begin
      issue(vecs[i]);
      drain("txn_timeout");
      check("wren_cycles", 32'(wren_cnt), 32'(vecs[i].we));
    end

    // Reset while the read sits in WAIT: aborted, no ack.
    @(negedge clock);
    req0 = 1; we0 = 0; addr0 = 6'h05;
    @(negedge clock);
    req0 = 0;
    @(negedge clock);
    check("in_wait_busy", 32'(busy), 32'd1);
    reset = 1;
    @(negedge clock);
    check_reset_outputs("midreset");
    reset = 0;
    repeat (6) @(negedge clock);
    check("post_abort_idle", 32'(busy), 32'd0);
    issue('{port:0, we:0, addr:6'h05, wdata:16'h0, exp:16'hBEEF});
    drain("after_reset_timeout");

    // req1 raised while port 0 waits: granted the edge after ack0's cycle.
    @(negedge clock);
    req0 = 1; we0 = 0; addr0 = 6'h01;
    e0 = cyc + 1;
    push_exp(0, 1, 16'h1111, e0 + 4);
    push_exp(1, 1, 16'h2222, e0 + 9);
    @(negedge clock);
    req0 = 0;
    @(negedge clock);
    req1 = 1; we1 = 0; addr1 = 6'h02;
    repeat (4) @(negedge clock);
    req1 = 0;
    drain("late_req1_timeout");

    // Continuous contention on both ports, four grants.
    @(negedge clock);
    req0 = 1; we0 = 0; addr0 = 6'h01;
    req1 = 1; we1 = 0; addr1 = 6'h02;
    e0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      push_exp(k[0], 1, k[0] ? 16'h2222 : 16'h1111, e0 + 5*k + 4);
`else
      push_exp(0, 1, 16'h1111, e0 + 5*k + 4);
`endif
    end
    done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0) done = 1;
    end
    req0 = 0; req1 = 0;
    check("contention_timeout", 32'(done), 32'd1);
    drain("contention_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
